alu_nibble_sequencer: RTL

//   Drives the 4-bit ALU (A, B, ALUop, Cin, enable_n, ALUbank in; result, NZVC flags out) as its initiator.

---
 rtl/alu_nibble_sequencer_if.sv | 47 ++++
 rtl/alu_nibble_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer_if.sv
// rtl/alu_nibble_sequencer_if.sv - control-unit request/response and nibble-ALU bus bundle
// Ports (signals): start, op_a, op_b, op_sel, op_bank, op_cin from the control unit;
//   busy, done, result_out, flags_out back to it; alu_a, alu_b, alu_op, alu_cin,
//   alu_enable_n, alu_bank to the ALU; alu_result, alu_flags from the ALU.
// Modports: master = control unit, slave = sequencer, alu = 4-bit ALU.
interface alu_nibble_sequencer_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [2:0]   op_sel;
    logic         op_bank;
    logic         op_cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result_out;
    logic [3:0]   flags_out;

    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [2:0]   alu_op;
    logic         alu_cin;
    logic         alu_enable_n;
    logic         alu_bank;
    logic [3:0]   alu_result;
    logic [3:0]   alu_flags;

    modport master (
        output start, op_a, op_b, op_sel, op_bank, op_cin,
        input  busy, done, result_out, flags_out
    );

    modport slave (
        input  start, op_a, op_b, op_sel, op_bank, op_cin,
        output busy, done, result_out, flags_out,
        output alu_a, alu_b, alu_op, alu_cin, alu_enable_n, alu_bank,
        input  alu_result, alu_flags
    );

    modport alu (
        input  alu_a, alu_b, alu_op, alu_cin, alu_enable_n, alu_bank,
        output alu_result, alu_flags
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - runs a wide operation as NIBBLES chained passes of a 4-bit ALU
// Ports: clock, reset (sync, active-high); bus (slave modport) carrying the control-unit
//   request/response and the ALU operand/result bus. Operands are latched on an accepted
//   start, nibble idx is presented each RUN cycle LS first, carry is chained between passes,
//   and the assembled result plus NZVC (N,V,C from MS pass, Z over all passes) is published
//   on the transition into DONE.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    alu_nibble_sequencer_if.slave bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             bank_q, bank_d;
    logic             carry_q, carry_d;
    logic             zacc_q, zacc_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       a_nib, b_nib;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            bank_q   <= 1'b0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            bank_q   <= bank_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        bank_d   = bank_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        acc_d    = acc_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    op_d    = bus.op_sel;
                    bank_d  = bus.op_bank;
                    // carry_q doubles as the nibble-0 carry-in, so alu_cin is always carry_q
                    carry_d = bus.op_cin;
                    zacc_d  = 1'b1;
                end
            end
            RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        acc_d[n*4 +: 4] = bus.alu_result;
                    end
                end
                carry_d = bus.alu_flags[0];
                zacc_d  = zacc_q & bus.alu_flags[2];
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                    // publish from the accumulator so result_out stays stable during RUN
                    result_d = acc_d;
                    flags_d  = {bus.alu_flags[3], zacc_d, bus.alu_flags[1], bus.alu_flags[0]};
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDX_W'(n)) begin
                a_nib = a_q[n*4 +: 4];
                b_nib = b_q[n*4 +: 4];
            end
        end
    end

    assign bus.busy         = (state_q == RUN);
    assign bus.done         = (state_q == DONE);
    assign bus.result_out   = result_q;
    assign bus.flags_out    = flags_q;
    assign bus.alu_a        = a_nib;
    assign bus.alu_b        = b_nib;
    assign bus.alu_op       = op_q;
    assign bus.alu_cin      = carry_q;
    assign bus.alu_bank     = bank_q;
    assign bus.alu_enable_n = (state_q != RUN);
endmodule
